// File: rtl/cpu_emissor_pkg.sv
// cpu_emissor_pkg: shared definitions for the CPU -> peripheral nibble link.
// Holds the handshake FSM state encoding and the data/counter widths so the
// peripheral-side code can decode the same states and widths.
package cpu_emissor_pkg;

  localparam int unsigned DATA_W = 4;  // nibble carried per transfer
  localparam int unsigned CNT_W  = 8;  // transfer counter and timeout counter width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } emissor_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single-bit level signal.
// Ports:
//   i_clk - destination clock
//   i_rst - asynchronous active-high reset, clears both flops
//   i_d   - asynchronous input level
//   o_q   - synchronized level, two i_clk edges behind i_d
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cpu_emissor.sv
// cpu_emissor: accepts nibbles from the CPU and sends each one to the
// peripheral with a four-phase handshake (send up, ack up, send down,
// ack down). A transfer that sees no ack within TIMEOUT_CYCLES cycles is
// abandoned with a one-cycle cpu_erro pulse.
//
// Optional feature: define CPU_EMISSOR_ACK_SYNC_EN to pass per_ack through a
// two-flop synchronizer (adds two cycles of ack-to-response latency).
// Without it per_ack is used directly.
//
// Ports:
//   cpu_clk       - single clock, rising edge
//   cpu_rst       - asynchronous active-high reset
//   cpu_valid     - CPU offers a nibble
//   cpu_dados     - nibble offered
//   cpu_ready     - block accepts a nibble this cycle (high only in IDLE)
//   per_send      - request line to the peripheral
//   out_per_dados - data to the peripheral, stable while per_send is high
//   per_ack       - acknowledge from the peripheral
//   cpu_erro      - one-cycle pulse on timeout
//   tx_count      - completed transfers, wraps at 255 -> 0
module cpu_emissor
  import cpu_emissor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64  // legal range 2..255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_dados,
  output logic              cpu_ready,
  output logic              per_send,
  output logic [DATA_W-1:0] out_per_dados,
  input  logic              per_ack,
  output logic              cpu_erro,
  output logic [CNT_W-1:0]  tx_count
);

  // Timeout fires on the TIMEOUT_CYCLES-th edge spent in SEND.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  emissor_state_e    r_state;
  logic [CNT_W-1:0]  r_tmo;
  logic [CNT_W-1:0]  r_tx_count;
  logic [DATA_W-1:0] r_dados;
  logic              r_send;
  logic              r_erro;
  logic              w_ack;

`ifdef CPU_EMISSOR_ACK_SYNC_EN
  sync_2ff u_ack_sync (
    .i_clk (cpu_clk),
    .i_rst (cpu_rst),
    .i_d   (per_ack),
    .o_q   (w_ack)
  );
`else
  assign w_ack = per_ack;
`endif

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_tx_count <= '0;
      r_dados    <= '0;
      r_send     <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_erro <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_valid) begin
            r_dados <= cpu_dados;
            r_send  <= 1'b1;
            r_tmo   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          // Ack is checked first so it wins over a timeout on the same edge.
          if (w_ack) begin
            r_send     <= 1'b0;
            r_tx_count <= r_tx_count + 1'b1;
            r_state    <= WAIT_LOW;
          end else if (r_tmo == TMO_LAST) begin
            r_send  <= 1'b0;
            r_erro  <= 1'b1;
            r_state <= WAIT_LOW;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!w_ack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_send  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ready     = (r_state == IDLE);
  assign per_send      = r_send;
  assign out_per_dados = r_dados;
  assign cpu_erro      = r_erro;
  assign tx_count      = r_tx_count;

endmodule

// File: doc/cpu_emissor.md
CPU_EMISSOR -- requirements
Module: cpu_emissor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the cycles allowed in SEND for per_ack to rise (legal range 2..255).
REQ-002 SHALL have port cpu_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cpu_valid, input, 1, CPU offers a nibble.
REQ-005 SHALL have port cpu_dados, input, 4, the nibble offered.
REQ-006 SHALL have port cpu_ready, output, 1, the block accepts a nibble this cycle.
REQ-007 SHALL have port per_send, output, 1, request line to the peripheral.
REQ-008 SHALL have port out_per_dados, output, 4, data to the peripheral, driving its in_per_dados.
REQ-009 SHALL have port per_ack, input, 1, acknowledge from the peripheral.
REQ-010 SHALL have port cpu_erro, output, 1, one-cycle pulse on timeout.
REQ-011 SHALL have port tx_count, output, 8, count of completed transfers.

Function
REQ-012 SHALL implement a four-phase handshake: raise per_send with out_per_dados stable, wait for ack=1, drop per_send, wait for ack=0.
REQ-013 SHALL use FSM states IDLE, SEND and WAIT_LOW.
REQ-014 In IDLE, cpu_ready SHALL be 1 and per_send SHALL be 0.
REQ-015 In IDLE, if cpu_valid=1 at an edge, the block SHALL latch cpu_dados into out_per_dados, set per_send=1 and enter SEND, all visible after that same edge.
REQ-016 In SEND, cpu_ready SHALL be 0 and per_send SHALL be 1.
REQ-017 In SEND, out_per_dados SHALL NOT change while per_send=1.
REQ-018 In SEND, on ack=1 the block SHALL clear per_send, increment tx_count (8-bit, 255 wraps to 0) and enter WAIT_LOW.
REQ-019 SEND SHALL keep a timeout counter, cleared on entry.
REQ-020 If ack is still 0 after TIMEOUT_CYCLES cycles in SEND, the block SHALL clear per_send, pulse cpu_erro for exactly one cycle, leave tx_count unchanged and enter WAIT_LOW.
REQ-021 In WAIT_LOW, per_send SHALL be 0 and cpu_ready SHALL be 0.
REQ-022 In WAIT_LOW, on ack=0 the block SHALL enter IDLE, and cpu_ready SHALL be 1 the following cycle.
REQ-023 WAIT_LOW SHALL have no timeout.
REQ-024 If ack=1 and the timeout expire on the same edge, ack SHALL win: count the transfer, no cpu_erro.
REQ-025 The block SHALL ignore cpu_valid outside IDLE; the CPU holds its data until it sees cpu_ready.
REQ-026 If ack is already 1 on entry to IDLE, the block SHALL still accept a nibble, and the transfer SHALL complete on the first SEND cycle.
REQ-027 "ack" in this section SHALL mean the internal sampled ack defined in Configuration.

Reset
REQ-028 When cpu_rst=1, the block SHALL asynchronously force state=IDLE, per_send=0, out_per_dados=4'h0, cpu_erro=0, tx_count=0, timeout counter=0 and synchronizer flops=0.
REQ-029 Reset mid-transfer SHALL drop per_send immediately without waiting for per_ack.
REQ-030 After reset deasserts, cpu_ready SHALL be 1.

Configuration
REQ-031 With macro CPU_EMISSOR_ACK_SYNC_EN defined, ack SHALL be per_ack passed through a two-flop synchronizer, adding 2 cycles of ack-to-response latency.
REQ-032 Without CPU_EMISSOR_ACK_SYNC_EN, ack SHALL be per_ack used directly with zero added latency, and no synchronizer flops SHALL exist.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, SEND, WAIT_LOW), the data-width constant (4) and the counter-width constant (8), for reuse by PERIFERICO-side code.
REQ-034 The synchronizer SHALL be one sub-module, sync_2ff, instantiated only under CPU_EMISSOR_ACK_SYNC_EN.

Verification
REQ-035 Single transfer: cpu_dados=4'hA with valid=1 in IDLE, peripheral acks after 3 cycles -> out_per_dados=4'hA held, per_send high until ack, tx_count=1, then cpu_ready=1.
REQ-036 Back-to-back: valid held with 4'h3 then 4'hC -> two complete four-phase cycles, data order 3,C, tx_count=2, never both per_send=1 and cpu_ready=1.
REQ-037 Timeout: TIMEOUT_CYCLES=8 and per_ack held 0 -> per_send drops after 8 SEND cycles, one cpu_erro pulse, tx_count unchanged, then IDLE.
REQ-038 Reset mid-SEND: cpu_rst pulsed while per_send=1 -> per_send=0 without waiting for a clock edge, all outputs at reset values.
REQ-039 Wrap: 256 transfers -> tx_count returns to 0.
REQ-040 Macro build: the same single transfer with CPU_EMISSOR_ACK_SYNC_EN defined -> per_send falls exactly 2 cycles later than in the build without it.
